// File: rtl/fc_pkg.sv
// Shared definitions for the FC2 argmax reader.
// Holds the default geometry of SRAM f (score count, score width, scores per
// word, address width), the class index width and the reader FSM state enum.
package fc_pkg;

  localparam int CLASS_NUM              = 10;
  localparam int DATA_WIDTH             = 8;
  localparam int DATA_NUM_PER_SRAM_ADDR = 4;
  localparam int SRAM_F_ADDR_WIDTH      = 10;
  localparam int CLASS_IDX_WIDTH        = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

endpackage

// File: rtl/lane_max4.sv
// Combinational running-max update for one SRAM f word of four signed lanes.
// Ports:
//   lanes_i    : packed word, lane 0 in the most significant byte
//   lane_vld_i : per-lane enable (bit j = lane j holds a real class score)
//   base_idx_i : class index of lane 0
//   max_i      : incoming running max (signed)
//   class_i    : incoming class of the running max
//   max_o      : updated running max
//   class_o    : updated class
// Lanes are visited in ascending index order and only a strictly greater
// score replaces the max, so ties keep the lowest class index.
module lane_max4
  import fc_pkg::*;
#(
  parameter int DW = DATA_WIDTH
) (
  input  logic [4*DW-1:0]              lanes_i,
  input  logic [3:0]                   lane_vld_i,
  input  logic [CLASS_IDX_WIDTH-1:0]   base_idx_i,
  input  logic signed [DW-1:0]         max_i,
  input  logic [CLASS_IDX_WIDTH-1:0]   class_i,
  output logic signed [DW-1:0]         max_o,
  output logic [CLASS_IDX_WIDTH-1:0]   class_o
);

  logic signed [DW-1:0] lane;

  always_comb begin
    max_o   = max_i;
    class_o = class_i;
    lane    = '0;
    for (int j = 0; j < 4; j++) begin
      lane = $signed(lanes_i[(3-j)*DW +: DW]);
      if (lane_vld_i[j] && (lane > max_o)) begin
        max_o   = lane;
        class_o = base_idx_i + CLASS_IDX_WIDTH'(j);
      end
    end
  end

endmodule

// File: rtl/fc_argmax_reader.sv
// Reads the FC2 scores out of SRAM f after fc_done and reports the index and
// value of the largest signed score through a valid/ready result port.
// Ports:
//   clk, srst        : clock, synchronous active-high reset
//   fc_done          : one-cycle pulse, SRAM f holds a complete result
//   sram_raddr_f     : SRAM f read address (0 whenever not reading)
//   sram_rdata_f     : SRAM f read data, one cycle after the address
//   result_valid     : result_class/result_score valid (HOLD state)
//   result_ready     : consumer accepts the result
//   result_class     : index of the maximum score
//   result_score     : maximum score (signed)
//   busy             : high in every state except IDLE
//   dbg_state_o      : current FSM state
// Handshake: the result transfers in the cycle where result_valid and
// result_ready are both high; result_valid then stays high and the outputs
// stay stable until that cycle, and drops at the following edge.
module fc_argmax_reader #(
  parameter int CLASS_NUM              = fc_pkg::CLASS_NUM,
  parameter int DATA_WIDTH             = fc_pkg::DATA_WIDTH,
  parameter int DATA_NUM_PER_SRAM_ADDR = fc_pkg::DATA_NUM_PER_SRAM_ADDR
) (
  input  logic                                         clk,
  input  logic                                         srst,
  input  logic                                         fc_done,
  output logic [fc_pkg::SRAM_F_ADDR_WIDTH-1:0]         sram_raddr_f,
  input  logic [DATA_NUM_PER_SRAM_ADDR*DATA_WIDTH-1:0] sram_rdata_f,
  output logic                                         result_valid,
  input  logic                                         result_ready,
  output logic [fc_pkg::CLASS_IDX_WIDTH-1:0]           result_class,
  output logic [DATA_WIDTH-1:0]                        result_score,
  output logic                                         busy,
  output fc_pkg::state_e                               dbg_state_o
);
  import fc_pkg::*;

  localparam int AW    = SRAM_F_ADDR_WIDTH;
  localparam int CW    = CLASS_IDX_WIDTH;
  localparam int WORDS = (CLASS_NUM + DATA_NUM_PER_SRAM_ADDR - 1) / DATA_NUM_PER_SRAM_ADDR;
  localparam logic [AW-1:0] LAST_ADDR = AW'(WORDS - 1);
  localparam logic signed [DATA_WIDTH-1:0] SCORE_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  state_e                       state_q, state_d;
  logic [AW-1:0]                addr_q, addr_d;
  // rd_vld_q marks that sram_rdata_f carries the word for rd_addr_q this cycle.
  logic                         rd_vld_q, rd_vld_d;
  logic [AW-1:0]                rd_addr_q, rd_addr_d;
  logic signed [DATA_WIDTH-1:0] max_q, max_d;
  logic [CW-1:0]                class_q, class_d;
  logic [CW-1:0]                res_class_q, res_class_d;
  logic [DATA_WIDTH-1:0]        res_score_q, res_score_d;

  logic [3:0]                   lane_vld;
  logic [CW-1:0]                base_idx;
  logic signed [DATA_WIDTH-1:0] upd_max;
  logic [CW-1:0]                upd_class;

  // Lanes past the last class in the final word are padding.
  always_comb begin
    lane_vld = '0;
    for (int j = 0; j < 4; j++) begin
      lane_vld[j] = ((int'(rd_addr_q) * DATA_NUM_PER_SRAM_ADDR + j) < CLASS_NUM);
    end
    base_idx = CW'(int'(rd_addr_q) * DATA_NUM_PER_SRAM_ADDR);
  end

  lane_max4 #(.DW(DATA_WIDTH)) u_lane_max4 (
    .lanes_i    (sram_rdata_f),
    .lane_vld_i (lane_vld),
    .base_idx_i (base_idx),
    .max_i      (max_q),
    .class_i    (class_q),
    .max_o      (upd_max),
    .class_o    (upd_class)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rd_vld_d    = 1'b0;
    rd_addr_d   = addr_q;
    max_d       = max_q;
    class_d     = class_q;
    res_class_d = res_class_q;
    res_score_d = res_score_q;

    if (rd_vld_q) begin
      max_d   = upd_max;
      class_d = upd_class;
    end

    case (state_q)
      ST_IDLE: begin
        addr_d = '0;
        if (fc_done) begin
          state_d = ST_READ;
          max_d   = SCORE_MIN;
          class_d = '0;
        end
      end
      ST_READ: begin
        rd_vld_d = 1'b1;
        if (addr_q == LAST_ADDR) begin
          state_d = ST_DRAIN;
          addr_d  = '0;
        end else begin
          addr_d = addr_q + AW'(1);
        end
      end
      ST_DRAIN: begin
        // The last word is in flight now; fold it straight into the result.
        state_d     = ST_HOLD;
        res_class_d = upd_class;
        res_score_d = upd_max;
      end
      ST_HOLD: begin
        if (result_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      rd_vld_q    <= 1'b0;
      rd_addr_q   <= '0;
      max_q       <= SCORE_MIN;
      class_q     <= '0;
      res_class_q <= '0;
      res_score_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rd_vld_q    <= rd_vld_d;
      rd_addr_q   <= rd_addr_d;
      max_q       <= max_d;
      class_q     <= class_d;
      res_class_q <= res_class_d;
      res_score_q <= res_score_d;
    end
  end

  assign sram_raddr_f = (state_q == ST_READ) ? addr_q : '0;
  assign result_valid = (state_q == ST_HOLD);
  assign busy         = (state_q != ST_IDLE);
  assign result_class = res_class_q;
  assign result_score = res_score_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_fc_argmax_reader.sv
// Directed bench for fc_argmax_reader with a one-cycle-latency SRAM f model.
module tb_fc_argmax_reader;
  import fc_pkg::*;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        srst;
  logic        fc_done;
  logic [9:0]  sram_raddr_f;
  logic [31:0] sram_rdata_f;
  logic        result_valid;
  logic        result_ready;
  logic [3:0]  result_class;
  logic [7:0]  result_score;
  logic        busy;
  state_e      dbg_state_o;

  fc_argmax_reader dut (
    .clk          (clk),
    .srst         (srst),
    .fc_done      (fc_done),
    .sram_raddr_f (sram_raddr_f),
    .sram_rdata_f (sram_rdata_f),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result_class (result_class),
    .result_score (result_score),
    .busy         (busy),
    .dbg_state_o  (dbg_state_o)
  );

  // SRAM f model: data for the address seen at an edge appears after it.
  logic [31:0] mem [0:3];
  always @(posedge clk) begin
    if (sram_raddr_f < 10'd4) sram_rdata_f <= mem[sram_raddr_f[1:0]];
    else                      sram_rdata_f <= 32'h0;
  end

  // Scoreboard counters
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_mem(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2);
    mem[0] = w0;
    mem[1] = w1;
    mem[2] = w2;
    mem[3] = 32'h0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, result_valid, 1'b0);
    chk({tag, "_busy"},  busy,         1'b0);
    chk({tag, "_addr"},  sram_raddr_f, 10'd0);
    chk({tag, "_class"}, result_class, 4'd0);
    chk({tag, "_score"}, result_score, 8'd0);
    chk({tag, "_state"}, dbg_state_o,  ST_IDLE);
  endtask

  // Pulse fc_done and follow the read with exact cycle checks; the result
  // must first be sampled high at the fifth edge after fc_done.
  task automatic run_op(input string tag, input logic [3:0] ec, input logic [7:0] es,
                        input bit do_ack);
    fc_done = 1'b1;
    step();
    fc_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk({tag, "_raddr"},  sram_raddr_f, 32'(i));
      chk({tag, "_nvalid"}, result_valid, 1'b0);
      chk({tag, "_busy"},   busy,         1'b1);
      step();
    end
    chk({tag, "_drain_state"}, dbg_state_o,  ST_DRAIN);
    chk({tag, "_drain_addr"},  sram_raddr_f, 10'd0);
    chk({tag, "_drain_valid"}, result_valid, 1'b0);
    step();
    chk({tag, "_valid"}, result_valid, 1'b1);
    chk({tag, "_class"}, result_class, ec);
    chk({tag, "_score"}, result_score, es);
    chk({tag, "_hold_addr"}, sram_raddr_f, 10'd0);
    if (do_ack) begin
      step();
      chk({tag, "_acked_valid"}, result_valid, 1'b0);
      chk({tag, "_acked_busy"},  busy,         1'b0);
      chk({tag, "_kept_class"},  result_class, ec);
      chk({tag, "_kept_score"},  result_score, es);
    end
  endtask

  initial begin
    srst         = 1'b1;
    fc_done      = 1'b0;
    result_ready = 1'b1;
    set_mem(32'h0, 32'h0, 32'h0);
    @(negedge clk);
    step();
    step();
    srst = 1'b0;
    chk_reset_outputs("reset");

    // Scores {3,-5,7,100,2,0,-1,99,100,4}: first 100 wins the tie.
    set_mem(32'h03FB0764, 32'h0200FF63, 32'h64040000);
    run_op("t1", 4'd3, 8'd100, 1'b1);

    // All -128, padding lanes 10/11 = 127 must be ignored.
    set_mem(32'h80808080, 32'h80808080, 32'h80807F7F);
    run_op("t2", 4'd0, 8'h80, 1'b1);

    // Max at the last class index.
    set_mem(32'h31313131, 32'h31313131, 32'h31327F7F);
    run_op("t3", 4'd9, 8'd50, 1'b1);

    // Backpressure: hold for 20 cycles while fc_done pulses are ignored.
    result_ready = 1'b0;
    set_mem(32'hFFFEFDFC, 32'h00000500, 32'h01020000);
    run_op("t4", 4'd6, 8'd5, 1'b0);
    set_mem(32'h03FB0764, 32'h0200FF63, 32'h64040000);
    for (int c = 0; c < 20; c++) begin
      fc_done = ((c % 5) == 0);
      step();
      fc_done = 1'b0;
      chk("t4_hold_valid", result_valid, 1'b1);
      chk("t4_hold_class", result_class, 4'd6);
      chk("t4_hold_score", result_score, 8'd5);
      chk("t4_hold_addr",  sram_raddr_f, 10'd0);
    end
    result_ready = 1'b1;
    fc_done      = 1'b1;
    step();
    fc_done = 1'b0;
    chk("t4_ack_valid", result_valid, 1'b0);
    chk("t4_ack_busy",  busy,         1'b0);
    chk("t4_ack_class", result_class, 4'd6);
    step();
    chk("t4_no_queue_busy", busy, 1'b0);
    run_op("t4_restart", 4'd3, 8'd100, 1'b1);

    // Reset in READ aborts with no result.
    set_mem(32'h31313131, 32'h31313131, 32'h31327F7F);
    fc_done = 1'b1;
    step();
    fc_done = 1'b0;
    step();
    chk("t5_read_addr", sram_raddr_f, 10'd1);
    srst = 1'b1;
    step();
    srst = 1'b0;
    chk_reset_outputs("t5_rst_read");
    for (int c = 0; c < 4; c++) begin
      step();
      chk("t5_no_partial_valid", result_valid, 1'b0);
      chk("t5_no_partial_busy",  busy,         1'b0);
    end
    run_op("t5_after_read_rst", 4'd9, 8'd50, 1'b1);

    // Reset in HOLD drops the pending result and clears the outputs.
    result_ready = 1'b0;
    set_mem(32'h80808080, 32'h80808080, 32'h80807F7F);
    run_op("t5_pre_hold", 4'd0, 8'h80, 1'b0);
    srst = 1'b1;
    step();
    srst = 1'b0;
    chk_reset_outputs("t5_rst_hold");
    result_ready = 1'b1;
    set_mem(32'h03FB0764, 32'h0200FF63, 32'h64040000);
    run_op("t5_after_hold_rst", 4'd3, 8'd100, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
